// File: rtl/jtag_pkg.sv
// rtl/jtag_pkg.sv - TAP state encodings, instruction opcodes and data-register select type
package jtag_pkg;

  // TAP controller state encodings (value seen on the STATE port)
  localparam logic [3:0] ST_TEST_LOGIC_RESET = 4'd0;
  localparam logic [3:0] ST_RUN_TEST_IDLE    = 4'd1;
  localparam logic [3:0] ST_SELECT_DR_SCAN   = 4'd2;
  localparam logic [3:0] ST_CAPTURE_DR       = 4'd3;
  localparam logic [3:0] ST_SHIFT_DR         = 4'd4;
  localparam logic [3:0] ST_EXIT1_DR         = 4'd5;
  localparam logic [3:0] ST_PAUSE_DR         = 4'd6;
  localparam logic [3:0] ST_EXIT2_DR         = 4'd7;
  localparam logic [3:0] ST_UPDATE_DR        = 4'd8;
  localparam logic [3:0] ST_SELECT_IR_SCAN   = 4'd9;
  localparam logic [3:0] ST_CAPTURE_IR       = 4'd10;
  localparam logic [3:0] ST_SHIFT_IR         = 4'd11;
  localparam logic [3:0] ST_EXIT1_IR         = 4'd12;
  localparam logic [3:0] ST_PAUSE_IR         = 4'd13;
  localparam logic [3:0] ST_EXIT2_IR         = 4'd14;
  localparam logic [3:0] ST_UPDATE_IR        = 4'd15;

  // Instruction opcodes; the top truncates these to its IR width
  localparam logic [31:0] OPC_IDCODE = 32'd1;
  localparam logic [31:0] OPC_USER   = 32'd2;

  // Which data register sits between TDI and TDO in the DR path
  typedef enum logic [1:0] {
    SEL_BYPASS = 2'd0,
    SEL_IDCODE = 2'd1,
    SEL_USER   = 2'd2
  } dr_sel_e;

  // BYPASS is the all-ones code of whatever IR width is in use
  function automatic logic [31:0] opc_bypass(input int unsigned w);
    if (w >= 32) begin
      return 32'hFFFF_FFFF;
    end
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// rtl/jtag_tap_fsm.sv - 16-state TAP controller driven by TMS on rising TCK
module tap_fsm
  import jtag_pkg::*;
(
  input  logic       TCK,
  input  logic       TRST,
  input  logic       TMS,
  output logic [3:0] STATE
);

  logic [3:0] state_q;
  logic [3:0] state_d;

  // Next-state table of the standard TAP diagram
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_TEST_LOGIC_RESET: state_d = TMS ? ST_TEST_LOGIC_RESET : ST_RUN_TEST_IDLE;
      ST_RUN_TEST_IDLE:    state_d = TMS ? ST_SELECT_DR_SCAN   : ST_RUN_TEST_IDLE;
      ST_SELECT_DR_SCAN:   state_d = TMS ? ST_SELECT_IR_SCAN   : ST_CAPTURE_DR;
      ST_CAPTURE_DR:       state_d = TMS ? ST_EXIT1_DR         : ST_SHIFT_DR;
      ST_SHIFT_DR:         state_d = TMS ? ST_EXIT1_DR         : ST_SHIFT_DR;
      ST_EXIT1_DR:         state_d = TMS ? ST_UPDATE_DR        : ST_PAUSE_DR;
      ST_PAUSE_DR:         state_d = TMS ? ST_EXIT2_DR         : ST_PAUSE_DR;
      ST_EXIT2_DR:         state_d = TMS ? ST_UPDATE_DR        : ST_SHIFT_DR;
      ST_UPDATE_DR:        state_d = TMS ? ST_SELECT_DR_SCAN   : ST_RUN_TEST_IDLE;
      ST_SELECT_IR_SCAN:   state_d = TMS ? ST_TEST_LOGIC_RESET : ST_CAPTURE_IR;
      ST_CAPTURE_IR:       state_d = TMS ? ST_EXIT1_IR         : ST_SHIFT_IR;
      ST_SHIFT_IR:         state_d = TMS ? ST_EXIT1_IR         : ST_SHIFT_IR;
      ST_EXIT1_IR:         state_d = TMS ? ST_UPDATE_IR        : ST_PAUSE_IR;
      ST_PAUSE_IR:         state_d = TMS ? ST_EXIT2_IR         : ST_PAUSE_IR;
      ST_EXIT2_IR:         state_d = TMS ? ST_UPDATE_IR        : ST_SHIFT_IR;
      ST_UPDATE_IR:        state_d = TMS ? ST_SELECT_DR_SCAN   : ST_RUN_TEST_IDLE;
      default:             state_d = ST_TEST_LOGIC_RESET;
    endcase
  end

  // State register; TRST forces TEST_LOGIC_RESET without waiting for TCK
  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      state_q <= ST_TEST_LOGIC_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  assign STATE = state_q;

endmodule

// File: rtl/jtag_tap.sv
// rtl/jtag_tap.sv - JTAG TAP with IR, BYPASS and USER registers; JTAG_TAP_IDCODE_EN adds IDCODE
module jtag_tap
  import jtag_pkg::*;
#(
  parameter int          IR_W       = 4,
  parameter int          DR_W       = 8,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
  input  logic            TCK,
  input  logic            TRST,
  input  logic            TMS,
  input  logic            TDI,
  output logic            TDO,
  output logic            TDO_EN,
  output logic [3:0]      STATE,
  output logic [IR_W-1:0] IR,
  input  logic [DR_W-1:0] DR_IN,
  output logic [DR_W-1:0] DR_OUT,
  output logic            DR_UPD
);

  localparam logic [31:0]     BYPASS32   = opc_bypass(IR_W);
  localparam logic [IR_W-1:0] OP_BYPASS  = BYPASS32[IR_W-1:0];
  localparam logic [IR_W-1:0] OP_USER    = OPC_USER[IR_W-1:0];
  localparam logic [IR_W-1:0] IR_CAPTURE = IR_W'(2'b01);
`ifdef JTAG_TAP_IDCODE_EN
  localparam logic [IR_W-1:0] OP_IDCODE  = OPC_IDCODE[IR_W-1:0];
  localparam logic [IR_W-1:0] RST_IR     = OP_IDCODE;
`else
  localparam logic [IR_W-1:0] RST_IR     = OP_BYPASS;
`endif

  logic [3:0]      state;
  dr_sel_e         dr_sel;

  logic [IR_W-1:0] ir_sr_q,   ir_sr_d;
  logic [IR_W-1:0] ir_q,      ir_d;
  logic            bypass_q,  bypass_d;
  logic [DR_W-1:0] user_sr_q, user_sr_d;
  logic [DR_W-1:0] dr_out_q,  dr_out_d;
  logic            dr_upd_q,  dr_upd_d;
`ifdef JTAG_TAP_IDCODE_EN
  logic [31:0]     idcode_sr_q, idcode_sr_d;
`endif

  tap_fsm u_fsm (
    .TCK   (TCK),
    .TRST  (TRST),
    .TMS   (TMS),
    .STATE (state)
  );

  // Instruction decode; unrecognised codes fall through to BYPASS
  always_comb begin
    dr_sel = SEL_BYPASS;
    if (ir_q == OP_USER) begin
      dr_sel = SEL_USER;
`ifdef JTAG_TAP_IDCODE_EN
    end else if (ir_q == OP_IDCODE) begin
      dr_sel = SEL_IDCODE;
`endif
    end
  end

  // Capture/shift/update actions keyed on the state being left at this edge
  always_comb begin
    ir_sr_d   = ir_sr_q;
    ir_d      = ir_q;
    bypass_d  = bypass_q;
    user_sr_d = user_sr_q;
    dr_out_d  = dr_out_q;
    dr_upd_d  = 1'b0;
`ifdef JTAG_TAP_IDCODE_EN
    idcode_sr_d = idcode_sr_q;
`endif
    case (state)
      ST_TEST_LOGIC_RESET: begin
        ir_d = RST_IR;
      end
      ST_CAPTURE_IR: begin
        ir_sr_d = IR_CAPTURE;
      end
      ST_SHIFT_IR: begin
        ir_sr_d = ir_sr_q >> 1;
        ir_sr_d[IR_W-1] = TDI;
      end
      ST_UPDATE_IR: begin
        ir_d = ir_sr_q;
      end
      ST_CAPTURE_DR: begin
        case (dr_sel)
          SEL_USER:   user_sr_d = DR_IN;
`ifdef JTAG_TAP_IDCODE_EN
          SEL_IDCODE: idcode_sr_d = IDCODE_VAL;
`endif
          default:    bypass_d = 1'b0;
        endcase
      end
      ST_SHIFT_DR: begin
        case (dr_sel)
          SEL_USER: begin
            user_sr_d = user_sr_q >> 1;
            user_sr_d[DR_W-1] = TDI;
          end
`ifdef JTAG_TAP_IDCODE_EN
          SEL_IDCODE: begin
            idcode_sr_d = {TDI, idcode_sr_q[31:1]};
          end
`endif
          default: begin
            bypass_d = TDI;
          end
        endcase
      end
      ST_UPDATE_DR: begin
        if (dr_sel == SEL_USER) begin
          dr_out_d = user_sr_q;
          dr_upd_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Register file; TRST clears everything and abandons any scan in flight
  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      ir_sr_q   <= '0;
      ir_q      <= RST_IR;
      bypass_q  <= 1'b0;
      user_sr_q <= '0;
      dr_out_q  <= '0;
      dr_upd_q  <= 1'b0;
    end else begin
      ir_sr_q   <= ir_sr_d;
      ir_q      <= ir_d;
      bypass_q  <= bypass_d;
      user_sr_q <= user_sr_d;
      dr_out_q  <= dr_out_d;
      dr_upd_q  <= dr_upd_d;
    end
  end

`ifdef JTAG_TAP_IDCODE_EN
  // IDCODE shift register, present only when the ID register is built in
  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      idcode_sr_q <= '0;
    end else begin
      idcode_sr_q <= idcode_sr_d;
    end
  end
`endif

  // TDO is the LSB of whichever register is shifting, forced low otherwise
  always_comb begin
    TDO = 1'b0;
    if (state == ST_SHIFT_IR) begin
      TDO = ir_sr_q[0];
    end else if (state == ST_SHIFT_DR) begin
      case (dr_sel)
        SEL_USER:   TDO = user_sr_q[0];
`ifdef JTAG_TAP_IDCODE_EN
        SEL_IDCODE: TDO = idcode_sr_q[0];
`endif
        default:    TDO = bypass_q;
      endcase
    end
  end

  assign TDO_EN = (state == ST_SHIFT_DR) || (state == ST_SHIFT_IR);
  assign STATE  = state;
  assign IR     = ir_q;
  assign DR_OUT = dr_out_q;
  assign DR_UPD = dr_upd_q;

endmodule

// File: doc/jtag_tap.md
JTAG_TAP -- requirements
Module: jtag_tap

Interface
REQ-001 SHALL have parameter IR_W, default 4, meaning instruction register width (>=2).
REQ-002 SHALL have parameter DR_W, default 8, meaning user data register width (>=1).
REQ-003 SHALL have parameter IDCODE_VAL, default 32'h1000_0001, meaning the 32-bit device ID (bit0 = 1).
REQ-004 SHALL have port TCK, input, 1, meaning the single clock; all logic is on the posedge.
REQ-005 SHALL have port TRST, input, 1, meaning reset; asynchronous, active-high.
REQ-006 SHALL have ports TMS, input, 1 (mode select) and TDI, input, 1 (serial data in).
REQ-007 SHALL have port TDO, output, 1, meaning serial data out.
REQ-008 SHALL have port TDO_EN, output, 1, meaning high only in SHIFT_DR or SHIFT_IR.
REQ-009 SHALL have port STATE, output, 4, meaning the current TAP state.
REQ-010 SHALL have port IR, output, IR_W, meaning the active instruction.
REQ-011 SHALL have port DR_IN, input, DR_W, meaning the user data sampled at capture.
REQ-012 SHALL have port DR_OUT, output, DR_W, meaning the registered user data.
REQ-013 SHALL have port DR_UPD, output, 1, meaning a one-cycle pulse when DR_OUT loads.

Function
REQ-014 SHALL encode STATE as: TEST_LOGIC_RESET=0, RUN_TEST_IDLE=1, SELECT_DR_SCAN=2, CAPTURE_DR=3, SHIFT_DR=4, EXIT1_DR=5, PAUSE_DR=6, EXIT2_DR=7, UPDATE_DR=8, SELECT_IR_SCAN=9, CAPTURE_IR=10, SHIFT_IR=11, EXIT1_IR=12, PAUSE_IR=13, EXIT2_IR=14, UPDATE_IR=15.
REQ-015 SHALL implement the IEEE 1149.1 16-state transitions on TMS; five consecutive TMS=1 clocks reach TEST_LOGIC_RESET from any state.
REQ-016 SHALL decode instructions: all-ones=BYPASS, 1=IDCODE, 2=USER; any other code behaves as BYPASS.
REQ-017 SHALL load the IR shift register with {zeros, 2'b01} on the clock leaving CAPTURE_IR.
REQ-018 SHALL shift on each clock in SHIFT_IR/SHIFT_DR LSB-first: TDI enters the MSB and TDO equals the LSB.
REQ-019 SHALL load IR from the IR shift register on the clock leaving UPDATE_IR; IR SHALL be unchanged by aborted scans (EXIT1->UPDATE without shift still updates with the captured 01 pattern).
REQ-020 SHALL, in CAPTURE_DR: BYPASS loads the 1-bit register with 0, IDCODE loads IDCODE_VAL, and USER loads DR_IN.
REQ-021 SHALL, on leaving UPDATE_DR with IR=USER, load DR_OUT from the USER shift register and assert DR_UPD for exactly that following cycle; other instructions leave DR_OUT unchanged.
REQ-022 SHALL set IR to the reset instruction synchronously on every clock spent in TEST_LOGIC_RESET.
REQ-023 SHALL drive TDO as 0 whenever TDO_EN=0.
REQ-024 SHALL give a BYPASS path delay of exactly one TCK from TDI to TDO.

Reset
REQ-025 SHALL, on TRST=1 regardless of TCK, immediately set STATE=0, IR=reset instruction, DR_OUT=0, DR_UPD=0, TDO_EN=0, TDO=0, and all shift registers to 0.
REQ-026 SHALL abandon any scan on reset mid-shift without updating IR or DR_OUT.

Configuration
REQ-027 SHALL, when macro JTAG_TAP_IDCODE_EN is defined, include the 32-bit IDCODE register and make IDCODE (1) the reset instruction.
REQ-028 SHALL, when JTAG_TAP_IDCODE_EN is undefined, exclude the IDCODE register, decode code 1 as BYPASS, and make BYPASS the reset instruction.

Structure
REQ-029 SHALL place the state encodings and the BYPASS/IDCODE/USER opcode constants in the shared package jtag_pkg.
REQ-030 SHALL implement the state machine as the sub-module tap_fsm (TCK, TRST, TMS -> STATE); the data registers and decode live in jtag_tap.

Verification
REQ-031 SHALL test reset: TRST pulsed mid-SHIFT_DR -> STATE=0, DR_OUT=0, and IR=1 (macro on) or 4'hF (macro off), with no TCK edge needed.
REQ-032 SHALL test TMS=1 for 5 clocks from SHIFT_IR -> STATE=0 and IR=reset instruction.
REQ-033 SHALL test an IR scan shifting 4'b0010 -> TDO yields 1,0,0,0 (capture pattern) and IR=2 after UPDATE_IR.
REQ-034 SHALL test USER: DR_IN=8'hA5 with 8'h3C shifted in -> TDO yields A5 LSB-first, DR_OUT=8'h3C, and DR_UPD is high for one cycle.
REQ-035 SHALL test IDCODE (macro on): 32 shifts after reset -> TDO yields IDCODE_VAL LSB-first, first bit 1.
REQ-036 SHALL test BYPASS: IR=4'hF with TDI pattern 1,0,1,1 -> TDO yields 0,1,0,1 (one-cycle delay, leading captured 0).
